// File: rtl/layer_compositor_pkg.sv
// Shared display types and constants for the layer compositor: screen ids,
// fade FSM states, background colour and the 8-bar test pattern geometry.
package layer_compositor_pkg;

    typedef enum logic [2:0] {
        START_SCREEN,
        SPRINT_MODE,
        MP_MODE,
        GAME_WON,
        GAME_LOST
    } game_screens_t;

    typedef enum logic [1:0] {
        IDLE,
        FADE_OUT,
        SWAP,
        FADE_IN
    } fade_state_t;

    localparam logic [23:0] BG_COLOR   = 24'h102030;

    localparam logic [9:0]  TP_ROW_END = 10'd240;
    localparam logic [9:0]  TP_COL_80  = 10'd80;
    localparam logic [9:0]  TP_COL_160 = 10'd160;
    localparam logic [9:0]  TP_COL_240 = 10'd240;
    localparam logic [9:0]  TP_COL_320 = 10'd320;
    localparam logic [9:0]  TP_COL_400 = 10'd400;
    localparam logic [9:0]  TP_COL_480 = 10'd480;
    localparam logic [9:0]  TP_COL_560 = 10'd560;

    // Eight 80-column bars in the top half; the black bar and the bottom half show the background.
    function automatic logic [23:0] tp_color(input logic [9:0] row, input logic [9:0] col);
        logic r, g, b;
        r = (col < TP_COL_160) || ((col >= TP_COL_320) && (col < TP_COL_480));
        g = (col < TP_COL_320);
        b = (col < TP_COL_80) || ((col >= TP_COL_160) && (col < TP_COL_240)) ||
            ((col >= TP_COL_320) && (col < TP_COL_400)) ||
            ((col >= TP_COL_480) && (col < TP_COL_560));
        if ((row >= TP_ROW_END) || !(r || g || b))
            tp_color = BG_COLOR;
        else
            tp_color = {{8{r}}, {8{g}}, {8{b}}};
    endfunction

endpackage

// File: rtl/layer_compositor_color_fader.sv
// Combinational per-channel brightness scaling: out = (channel * level) >> FADE_LOG2.
module color_fader #(
    parameter int FADE_LOG2 = 3
) (
    input  logic [23:0]        color_in,
    input  logic [FADE_LOG2:0] level,
    output logic [23:0]        color_out
);

    localparam int PW = 8 + FADE_LOG2 + 1;

    // level never exceeds 2**FADE_LOG2, so the shifted product always fits in 8 bits.
    for (genvar c = 0; c < 3; c++) begin : g_ch
        logic [PW-1:0] prod;
        assign prod = PW'(color_in[c*8 +: 8]) * PW'(level);
        assign color_out[c*8 +: 8] = prod[FADE_LOG2 +: 8];
    end

endmodule

// File: rtl/layer_compositor.sv
// Priority compositor over NUM_LAYERS pixel drivers with a frame-synchronous
// fade-out / screen-swap / fade-in sequencer and a 2-stage pixel pipeline.
module layer_compositor
    import layer_compositor_pkg::*;
#(
    parameter int NUM_LAYERS      = 6,
    parameter int FADE_LOG2       = 3,
    parameter int FRAMES_PER_STEP = 2
) (
    input  logic                        clk,
    input  logic                        rst_l,
    input  logic                        frame_start,
    input  logic [9:0]                  VGA_row,
    input  logic [9:0]                  VGA_col,
    input  logic [NUM_LAYERS-1:0][23:0] layer_color,
    input  logic [NUM_LAYERS-1:0]       layer_active,
    input  logic [NUM_LAYERS-1:0]       layer_enable,
    input  game_screens_t               req_screen,
    input  logic                        testpattern_active,
    output game_screens_t               shown_screen,
    output logic                        transition_busy,
    output logic [23:0]                 output_color
);

    localparam int FADE_STEPS = 1 << FADE_LOG2;
    localparam int LW         = FADE_LOG2 + 1;

    fade_state_t           state, state_nxt;
    logic [LW-1:0]         level, level_nxt;
    logic [3:0]            step_cnt, step_nxt;
    game_screens_t         target, target_nxt, shown_nxt;
    logic                  step_done;

    logic [NUM_LAYERS-1:0] en_q, en_eff;
    logic [23:0]           pick, s1_color, s1_nxt, faded;
    logic                  s1_bypass;

    assign step_done = frame_start && (step_cnt == 4'(FRAMES_PER_STEP - 1));

    always_comb begin
        state_nxt  = state;
        level_nxt  = level;
        step_nxt   = step_cnt;
        target_nxt = target;
        shown_nxt  = shown_screen;
        case (state)
            IDLE: begin
                if (frame_start && (req_screen != shown_screen)) begin
                    state_nxt  = FADE_OUT;
                    target_nxt = req_screen;
                    step_nxt   = '0;
                end
            end
            FADE_OUT: begin
                // The destination stays retargetable until the swap frame.
                target_nxt = req_screen;
                if (step_done) begin
                    step_nxt  = '0;
                    level_nxt = level - LW'(1);
                    if (level == LW'(1)) begin
                        state_nxt = SWAP;
                        shown_nxt = target_nxt;
                    end
                end else if (frame_start) begin
                    step_nxt = step_cnt + 4'd1;
                end
            end
            SWAP: begin
                if (frame_start) begin
                    state_nxt = FADE_IN;
                    step_nxt  = '0;
                end
            end
            FADE_IN: begin
                if (step_done) begin
                    step_nxt  = '0;
                    level_nxt = level + LW'(1);
                    if (level == LW'(FADE_STEPS - 1))
                        state_nxt = IDLE;
                end else if (frame_start) begin
                    step_nxt = step_cnt + 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state           <= IDLE;
            level           <= LW'(FADE_STEPS);
            step_cnt        <= '0;
            target          <= START_SCREEN;
            shown_screen    <= START_SCREEN;
            transition_busy <= 1'b0;
            en_q            <= '1;
        end else begin
            state           <= state_nxt;
            level           <= level_nxt;
            step_cnt        <= step_nxt;
            target          <= target_nxt;
            shown_screen    <= shown_nxt;
            transition_busy <= (state_nxt != IDLE);
            if (frame_start)
                en_q <= layer_enable;
        end
    end

    // A new enable mask is honoured on the frame_start pixel itself, never mid-frame.
    assign en_eff = frame_start ? layer_enable : en_q;

    always_comb begin
        pick = BG_COLOR;
        for (int i = 0; i < NUM_LAYERS; i++)
            if (layer_active[i] && en_eff[i])
                pick = layer_color[i];
    end

    assign s1_nxt = testpattern_active ? tp_color(VGA_row, VGA_col) : pick;

    color_fader #(.FADE_LOG2(FADE_LOG2)) u_fader (
        .color_in  (s1_color),
        .level     (level),
        .color_out (faded)
    );

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            s1_color     <= BG_COLOR;
            s1_bypass    <= 1'b0;
            output_color <= BG_COLOR;
        end else begin
            s1_color     <= s1_nxt;
            s1_bypass    <= testpattern_active;
            output_color <= s1_bypass ? s1_color : faded;
        end
    end

endmodule
